// File: rtl/mxint_cast.sv
// MXINT cast: renormalises a wide-mantissa block to OUT_MAN_W-bit mantissas with an adjusted shared exponent.
// Optional round-half-up on the right shift when MXINT_CAST_ROUND_EN is defined; otherwise truncation toward -inf.
module mxint_cast #(
   parameter int IN_MAN_W   = 10,
   parameter int OUT_MAN_W  = 4,
   parameter int EXP_W      = 8,
   parameter int BLOCK_SIZE = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_MAN_W-1:0]  mdata_in_0 [BLOCK_SIZE],
   input  logic [EXP_W-1:0]     edata_in_0,
   input  logic                 data_in_0_valid,
   output logic                 data_in_0_ready,
   output logic [OUT_MAN_W-1:0] mdata_out_0 [BLOCK_SIZE],
   output logic [EXP_W-1:0]     edata_out_0,
   output logic                 data_out_0_valid,
   input  logic                 data_out_0_ready
);

   localparam int SH_W = $clog2(IN_MAN_W) + 1;

   localparam logic signed [IN_MAN_W:0] MAN_MAX = (IN_MAN_W+1)'((1 << (OUT_MAN_W-1)) - 1);
   localparam logic signed [IN_MAN_W:0] MAN_MIN = (IN_MAN_W+1)'(-(1 << (OUT_MAN_W-1)));
   localparam logic [OUT_MAN_W-1:0]     OUT_MAX = {1'b0, {(OUT_MAN_W-1){1'b1}}};
   localparam logic [OUT_MAN_W-1:0]     OUT_MIN = {1'b1, {(OUT_MAN_W-1){1'b0}}};
   localparam logic signed [EXP_W:0]    EXP_MAX = (EXP_W+1)'((1 << (EXP_W-1)) - 1);
   localparam logic [EXP_W-1:0]         EXP_MAX_OUT = {1'b0, {(EXP_W-1){1'b1}}};
   localparam logic [EXP_W-1:0]         MIN_EXP = {1'b1, {(EXP_W-1){1'b0}}};

   logic                s1_valid_reg;
   logic [IN_MAN_W-1:0] s1_man_reg [BLOCK_SIZE];
   logic [EXP_W-1:0]    s1_exp_reg;
   logic [SH_W-1:0]     s1_shift_reg;
   logic                s1_zero_reg;

   logic                s2_can_load;
   logic [BLOCK_SIZE*SH_W-1:0]      len_flat;
   logic [BLOCK_SIZE-1:0]           lane_zero;
   logic [SH_W-1:0]                 max_len;
   logic [SH_W-1:0]                 shift_next;
   logic [BLOCK_SIZE*OUT_MAN_W-1:0] lane_out_flat;
   logic signed [EXP_W:0]           exp_sum;
   logic                            exp_ovf;

   assign s2_can_load     = !data_out_0_valid || data_out_0_ready;
   assign data_in_0_ready = !s1_valid_reg || s2_can_load;

   // Signed bit length: fold negatives onto their complement, then the highest set bit + 2.
   generate
      for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_len
         logic [IN_MAN_W-1:0] folded;
         logic [SH_W-1:0]     lane_len;
         assign folded = mdata_in_0[gi] ^ {IN_MAN_W{mdata_in_0[gi][IN_MAN_W-1]}};
         always_comb begin
            lane_len = SH_W'(1);
            for (int b = 0; b < IN_MAN_W-1; b++) begin
               if (folded[b]) lane_len = SH_W'(b + 2);
            end
         end
         assign len_flat[gi*SH_W +: SH_W] = lane_len;
         assign lane_zero[gi] = (mdata_in_0[gi] == '0);
      end
   endgenerate

   always_comb begin
      max_len = SH_W'(1);
      for (int i = 0; i < BLOCK_SIZE; i++) begin
         if (len_flat[i*SH_W +: SH_W] > max_len) max_len = len_flat[i*SH_W +: SH_W];
      end
   end

   assign shift_next = (max_len > SH_W'(OUT_MAN_W)) ? max_len - SH_W'(OUT_MAN_W) : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_reg <= 1'b0;
         s1_exp_reg   <= '0;
         s1_shift_reg <= '0;
         s1_zero_reg  <= 1'b0;
         for (int i = 0; i < BLOCK_SIZE; i++) s1_man_reg[i] <= '0;
      end else if (data_in_0_ready) begin
         s1_valid_reg <= data_in_0_valid;
         if (data_in_0_valid) begin
            s1_exp_reg   <= edata_in_0;
            s1_shift_reg <= shift_next;
            s1_zero_reg  <= &lane_zero;
            for (int i = 0; i < BLOCK_SIZE; i++) s1_man_reg[i] <= mdata_in_0[i];
         end
      end
   end

   // One guard bit keeps e + s from wrapping before the overflow test.
   assign exp_sum = {s1_exp_reg[EXP_W-1], s1_exp_reg} + (EXP_W+1)'(s1_shift_reg);
   assign exp_ovf = exp_sum > EXP_MAX;

   generate
      for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_lane
         logic signed [IN_MAN_W:0] ext;
         logic signed [IN_MAN_W:0] shifted;
         logic [OUT_MAN_W-1:0]     lane_out;
         assign ext = $signed({s1_man_reg[gi][IN_MAN_W-1], s1_man_reg[gi]});
`ifdef MXINT_CAST_ROUND_EN
         logic signed [IN_MAN_W:0] rnd_bias;
         logic signed [IN_MAN_W:0] biased;
         assign rnd_bias = (s1_shift_reg == '0) ? '0
                         : $signed((IN_MAN_W+1)'(1) << (s1_shift_reg - SH_W'(1)));
         assign biased   = ext + rnd_bias;
         assign shifted  = biased >>> s1_shift_reg;
`else
         assign shifted  = ext >>> s1_shift_reg;
`endif
         always_comb begin
            if (s1_zero_reg) begin
               lane_out = '0;
            end else if (exp_ovf) begin
               if (ext < 0)       lane_out = OUT_MIN;
               else if (ext == 0) lane_out = '0;
               else               lane_out = OUT_MAX;
            end else if (shifted > MAN_MAX) begin
               lane_out = OUT_MAX;
            end else if (shifted < MAN_MIN) begin
               lane_out = OUT_MIN;
            end else begin
               lane_out = shifted[OUT_MAN_W-1:0];
            end
         end
         assign lane_out_flat[gi*OUT_MAN_W +: OUT_MAN_W] = lane_out;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out_0_valid <= 1'b0;
         edata_out_0      <= MIN_EXP;
         for (int i = 0; i < BLOCK_SIZE; i++) mdata_out_0[i] <= '0;
      end else if (s2_can_load) begin
         data_out_0_valid <= s1_valid_reg;
         if (s1_valid_reg) begin
            if (s1_zero_reg)  edata_out_0 <= MIN_EXP;
            else if (exp_ovf) edata_out_0 <= EXP_MAX_OUT;
            else              edata_out_0 <= exp_sum[EXP_W-1:0];
            for (int i = 0; i < BLOCK_SIZE; i++) mdata_out_0[i] <= lane_out_flat[i*OUT_MAN_W +: OUT_MAN_W];
         end
      end
   end

endmodule
